// File: rtl/core_pkg.sv
// Shared core types: XLEN, the canonical NOP, fetch entry layout and counter sizing.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            err;
    } fetch_entry_t;

    // Width needed to hold a count in the range 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and a registered head entry.
// Storage is a plain array so it can map onto distributed or block RAM.
module sync_fifo
    import core_pkg::cnt_width;
#(
    parameter type T          = logic [7:0],
    parameter int  DEPTH      = 4,
    localparam int CW         = cnt_width(DEPTH),
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  T              wdata_i,
    input  logic          pop_i,
    output T              head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    T              mem [DEPTH];
    T              head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = head_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        // Head tracks the oldest entry; the pushed word goes straight to it
        // whenever it becomes the only entry.
        if (flush_i || count_d == '0) begin
            head_d   = '0;
        end else if (empty_o || (do_pop && count_q == CW'(1))) begin
            head_d   = wdata_i;
        end else if (do_pop) begin
            head_d   = mem[rd_ptr_q + AW'(1)];
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch requests, in-order responses into a FIFO,
// stale-response discard after redirects. Build option IF_PFQ_PERF_EN enables perf counters.
module if_prefetch_queue
    import core_pkg::cnt_width;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            err_o,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_discarded_o
);

    localparam int CW = cnt_width(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            err;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic            grant, resp_keep, fifo_pop;
    entry_t          push_entry, head;

    // Slots already spoken for: queued entries plus responses still to be kept.
    assign in_use     = {1'b0, fifo_count} + {1'b0, outstanding_q} - {1'b0, discard_q};
    assign imem_req_o = !rst && !redirect_i && !fifo_full && (in_use < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign grant      = imem_req_o && imem_gnt_i;

    assign redirect_pc_aligned = redirect_pc_i & ~(XLEN'(3));
    assign resp_keep  = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign fifo_pop   = valid_o && ready_i && !redirect_i;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i, err: imem_err_i};

    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            // Everything still in flight belongs to the old stream.
            discard_d  = outstanding_q - CW'(imem_rvalid_i);
        end else begin
            if (grant)                                 fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rvalid_i && discard_q != '0)      discard_d  = discard_q - CW'(1);
            if (resp_keep)                             resp_pc_d  = resp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (resp_keep),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign pc_o    = head.pc;
    assign instr_o = head.instr;
    assign err_o   = head.err;

`ifdef IF_PFQ_PERF_EN
    logic        resp_drop;
    logic [31:0] perf_fetched_q, perf_discarded_q;

    // Responses landing in a redirect cycle belong to the abandoned stream.
    assign resp_drop = imem_rvalid_i && !resp_keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_q + 32'(resp_keep);
            perf_discarded_q <= perf_discarded_q + 32'(resp_drop);
        end
    end

    assign perf_fetched_o   = perf_fetched_q;
    assign perf_discarded_o = perf_discarded_q;
`else
    assign perf_fetched_o   = '0;
    assign perf_discarded_o = '0;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a vector table for fill/drain streaming plus
// hand-written redirect, error and mid-stream reset sequences against a bench memory model.
module tb_if_prefetch_queue;

`ifdef IF_PFQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        err_o;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_discarded_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_en = 1'b1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int resp_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    typedef struct {
        bit          rst;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tv[16];

    if_prefetch_queue dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .imem_err_i       (imem_err_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .instr_o          (instr_o),
        .err_o            (err_o),
        .perf_fetched_o   (perf_fetched_o),
        .perf_discarded_o (perf_discarded_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h5A00_0013 ^ {a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model acts at the falling edge, then the DUT samples at the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (rst) begin
            mq.delete();
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            imem_err_i    = 1'b0;
        end else begin
            imem_gnt_i = gnt_en;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word_at(mq[0].addr);
                imem_err_i    = (mq[0].addr == err_addr);
                if (!redirect_i) resp_cnt++;
                void'(mq.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
                imem_err_i    = 1'b0;
            end
            if (imem_req_o && imem_gnt_i) mq.push_back('{imem_addr_o, cyc + lat});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        rst        = 1'b1;
        redirect_i = 1'b0;
        ready_i    = rdy;
        cycle();
        cycle();
        rst      = 1'b0;
        cyc      = 0;
        resp_cnt = 0;
        #1;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 20 && !valid_o; k++) cycle();
        chk("wait_valid", 32'(valid_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, ready, exp_req, exp_addr, exp_valid, exp_pc
        tv[0]  = '{1, 0, 0, 32'h00, 0, 32'h00};
        tv[1]  = '{0, 0, 1, 32'h00, 0, 32'h00};
        tv[2]  = '{0, 0, 1, 32'h04, 0, 32'h00};
        tv[3]  = '{0, 0, 1, 32'h08, 1, 32'h00};
        tv[4]  = '{0, 0, 1, 32'h0C, 1, 32'h00};
        tv[5]  = '{0, 0, 0, 32'h00, 1, 32'h00};
        tv[6]  = '{0, 0, 0, 32'h00, 1, 32'h00};
        tv[7]  = '{0, 0, 0, 32'h00, 1, 32'h00};
        tv[8]  = '{0, 1, 0, 32'h00, 1, 32'h00};
        tv[9]  = '{0, 1, 1, 32'h10, 1, 32'h04};
        tv[10] = '{0, 1, 1, 32'h14, 1, 32'h08};
        tv[11] = '{0, 1, 1, 32'h18, 1, 32'h0C};
        tv[12] = '{0, 1, 1, 32'h1C, 1, 32'h10};
        tv[13] = '{0, 1, 1, 32'h20, 1, 32'h14};
        tv[14] = '{0, 1, 1, 32'h24, 1, 32'h18};
        tv[15] = '{0, 1, 1, 32'h28, 1, 32'h1C};

        // Fill with decode stalled, then drain with zero-wait memory.
        lat = 1;
        gnt_en = 1'b1;
        do_reset(1'b0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rst     = tv[i].rst;
            ready_i = tv[i].ready;
            if (i == 1) begin
                cyc = 0;
                resp_cnt = 0;
            end
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(tv[i].exp_req));
            if (tv[i].exp_req) chk($sformatf("v%0d_addr", i), imem_addr_o, tv[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tv[i].exp_valid));
            if (tv[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), pc_o, tv[i].exp_pc);
                chk($sformatf("v%0d_instr", i), instr_o, word_at(tv[i].exp_pc));
            end
            if (tv[i].rst) begin
                chk("reset_pc", pc_o, 32'h0);
                chk("reset_instr", instr_o, 32'h0);
                chk("reset_err", 32'(err_o), 32'h0);
                chk("reset_perf_f", perf_fetched_o, 32'h0);
            end
            cycle();
        end
        chk("perf_fetched", perf_fetched_o, PERF ? 32'(resp_cnt) : 32'h0);

        // Redirect with two late responses in flight.
        lat = 3;
        do_reset(1'b1);
        chk("b_req0", imem_addr_o, 32'h0);
        cycle();
        chk("b_req1", imem_addr_o, 32'h4);
        cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        #1;
        chk("b_redir_req", 32'(imem_req_o), 32'h0);
        cycle();
        redirect_i = 1'b0;
        #1;
        chk("b_new_req", 32'(imem_req_o), 32'h1);
        chk("b_new_addr", imem_addr_o, 32'h100);
        wait_valid();
        chk("b_first_pc", pc_o, 32'h100);
        chk("b_first_instr", instr_o, word_at(32'h100));
        chk("b_perf_disc", perf_discarded_o, PERF ? 32'd2 : 32'd0);

        // Redirect in the same cycle as the only outstanding response.
        lat = 2;
        gnt_en = 1'b1;
        do_reset(1'b1);
        chk("c_addr0", imem_addr_o, 32'h0);
        cycle();
        gnt_en = 1'b0;
        chk("c_addr_hold", imem_addr_o, 32'h4);
        cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        #1;
        chk("c_redir_rvalid", 32'(imem_rvalid_i), 32'h0);
        cycle();
        redirect_i = 1'b0;
        gnt_en     = 1'b1;
        #1;
        chk("c_dropped", 32'(valid_o), 32'h0);
        chk("c_new_addr", imem_addr_o, 32'h200);
        wait_valid();
        chk("c_first_pc", pc_o, 32'h200);
        chk("c_first_instr", instr_o, word_at(32'h200));

        // Error on the response for PC 0x8.
        lat = 1;
        err_addr = 32'h8;
        do_reset(1'b1);
        for (int k = 0; k < 20 && !(valid_o && pc_o == 32'h8); k++) cycle();
        chk("d_err_pc", pc_o, 32'h8);
        chk("d_err_flag", 32'(err_o), 32'h1);
        chk("d_err_instr", instr_o, word_at(32'h8));
        cycle();
        chk("d_next_valid", 32'(valid_o), 32'h1);
        chk("d_next_pc", pc_o, 32'hC);
        chk("d_next_err", 32'(err_o), 32'h0);
        err_addr = 32'hFFFF_FFFF;

        // Reset with two entries queued and two requests in flight.
        lat = 3;
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) cycle();
        chk("e_half_full", 32'(valid_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("e_rst_req", 32'(imem_req_o), 32'h0);
        cycle();
        chk("e_rst_valid", 32'(valid_o), 32'h0);
        chk("e_rst_req2", 32'(imem_req_o), 32'h0);
        cycle();
        rst     = 1'b0;
        cyc     = 0;
        ready_i = 1'b1;
        #1;
        chk("e_restart_req", 32'(imem_req_o), 32'h1);
        chk("e_restart_addr", imem_addr_o, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("e_no_stale%0d", k), 32'(valid_o), 32'h0);
            cycle();
        end
        wait_valid();
        chk("e_first_pc", pc_o, 32'h0);
        cycle();
        chk("e_second_pc", pc_o, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
